// File: rtl/add_serial_param.sv
// Parametrised bit-serial adder/subtractor with keyed operand masking and valid/ready handshakes.
// Optional build macro ADD_SERIAL_SAT_EN: saturate the result on signed overflow instead of wrapping.
module add_serial_param #(
    parameter int               WIDTH      = 8,
    parameter int               DIGIT      = 1,
    parameter int               LOAD_DELAY = 3,
    parameter logic [WIDTH-1:0] A_KEY      = '0,
    parameter logic [WIDTH-1:0] B_KEY      = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int WW   = (LOAD_DELAY > 1) ? $clog2(LOAD_DELAY) : 1;

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("add_serial_param: DIGIT must be >= 1 and divide WIDTH");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ADD, S_DONE} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] op_a_in, op_b_in;
    logic [WIDTH-1:0] out_shift;
    logic [DIGIT:0]   dsum;
    logic [CW-1:0]    dcnt;
    logic [WW-1:0]    wcnt;
    logic             carry, msb_a, msb_b, ovf_r;
    logic             last_digit, wait_done, ovf_nxt;

    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        logic [WIDTH-1:0] v;
        v = {1'b0, {(WIDTH-1){1'b1}}};
        return neg ? ~v : v;
    endfunction

    assign op_a_in    = a ^ A_KEY;
    assign op_b_in    = sub ? ~(b ^ B_KEY) : (b ^ B_KEY);
    assign last_digit = (dcnt == CW'(NDIG - 1));
    assign wait_done  = (wcnt == WW'(LOAD_DELAY - 1));

    // Digit adder: the new sum digit enters out from the MSB end
    assign dsum      = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + (DIGIT+1)'(carry);
    assign out_shift = (out >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign ovf_nxt   = (msb_a == msb_b) && (out_shift[WIDTH-1] != msb_a);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid) state_nxt = (LOAD_DELAY > 0) ? S_WAIT : S_ADD;
            S_WAIT: if (wait_done) state_nxt = S_ADD;
            S_ADD:  if (last_digit) state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            out   <= '0;
            carry <= 1'b0;
            msb_a <= 1'b0;
            msb_b <= 1'b0;
            ovf_r <= 1'b0;
            dcnt  <= '0;
            wcnt  <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    op_a  <= op_a_in;
                    op_b  <= op_b_in;
                    carry <= sub;
                    out   <= '0;
                    msb_a <= op_a_in[WIDTH-1];
                    msb_b <= op_b_in[WIDTH-1];
                    ovf_r <= 1'b0;
                    dcnt  <= '0;
                    wcnt  <= '0;
                end
                S_WAIT: wcnt <= wcnt + 1'b1;
                S_ADD: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    carry <= dsum[DIGIT];
                    dcnt  <= dcnt + 1'b1;
                    out   <= out_shift;
                    if (last_digit) begin
                        ovf_r <= ovf_nxt;
`ifdef ADD_SERIAL_SAT_EN
                        if (ovf_nxt) out <= sat_value(msb_a);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign cout      = carry;
    assign ovf       = ovf_r;

`ifndef ADD_SERIAL_SAT_EN
    logic unused_sat;
    assign unused_sat = ^sat_value(1'b0);
`endif

endmodule

// File: tb/tb_add_serial_param.sv
// Directed bench for add_serial_param: default, keyed and 16-bit/4-bit-digit instances.
module tb_add_serial_param;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       in_ready0, out_valid0, cout0, ovf0;
    logic [7:0] out0;
    logic       in_ready2, out_valid2, cout2, ovf2;
    logic [7:0] out2;

    logic        in_valid1 = 1'b0, sub1 = 1'b0, out_ready1 = 1'b0;
    logic [15:0] a1 = '0, b1 = '0;
    logic        in_ready1, out_valid1, cout1, ovf1;
    logic [15:0] out1;

    int n_vec = 0;
    int n_err = 0;

`ifdef ADD_SERIAL_SAT_EN
    localparam logic [7:0] EXP_OVF_POS = 8'h7F;
    localparam logic [7:0] EXP_OVF_NEG = 8'h80;
`else
    localparam logic [7:0] EXP_OVF_POS = 8'h80;
    localparam logic [7:0] EXP_OVF_NEG = 8'h7F;
`endif

    always #5 clk = ~clk;

    add_serial_param dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b), .sub(sub),
        .out_valid(out_valid0), .out_ready(out_ready), .out(out0), .cout(cout0), .ovf(ovf0)
    );

    add_serial_param #(.A_KEY(8'h66), .B_KEY(8'hB2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b), .sub(sub),
        .out_valid(out_valid2), .out_ready(out_ready), .out(out2), .cout(cout2), .ovf(ovf2)
    );

    add_serial_param #(.WIDTH(16), .DIGIT(4), .LOAD_DELAY(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out(out1), .cout(cout1), .ovf(ovf1)
    );

    // Issue one operand pair to the 8-bit instances; lat = edges from accept to out_valid.
    task automatic xact(input logic [7:0] ta, input logic [7:0] tb, input logic ts, output int lat);
        @(negedge clk);
        a = ta; b = tb; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid0 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_vec++; if (out0 !== 8'h00) begin n_err++; $display("FAIL reset_out got %h exp 00", out0); end
        n_vec++; if (cout0 !== 1'b0 || ovf0 !== 1'b0) begin n_err++; $display("FAIL reset_flags got cout=%b ovf=%b exp 0 0", cout0, ovf0); end
        n_vec++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin n_err++; $display("FAIL reset_hs got out_valid=%b in_ready=%b exp 0 1", out_valid0, in_ready0); end
        rst = 1'b0;
    endtask

    task automatic test_add;
        int lat;
        n_vec++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL add_in_ready got %b exp 1", in_ready0); end
        xact(8'h35, 8'h4A, 1'b0, lat);
        n_vec++; if (lat != 11) begin n_err++; $display("FAIL add_latency got %0d exp 11", lat); end
        n_vec++; if (out0 !== 8'h7F) begin n_err++; $display("FAIL add_out got %h exp 7f", out0); end
        n_vec++; if (cout0 !== 1'b0 || ovf0 !== 1'b0) begin n_err++; $display("FAIL add_flags got cout=%b ovf=%b exp 0 0", cout0, ovf0); end
        release_out();
        n_vec++; if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin n_err++; $display("FAIL add_release got in_ready=%b out_valid=%b exp 1 0", in_ready0, out_valid0); end
        n_vec++; if (out0 !== 8'h7F) begin n_err++; $display("FAIL add_hold_idle got %h exp 7f", out0); end
    endtask

    task automatic test_overflow;
        int lat;
        xact(8'h7F, 8'h01, 1'b0, lat);
        n_vec++; if (out0 !== EXP_OVF_POS) begin n_err++; $display("FAIL ovf_pos_out got %h exp %h", out0, EXP_OVF_POS); end
        n_vec++; if (cout0 !== 1'b0 || ovf0 !== 1'b1) begin n_err++; $display("FAIL ovf_pos_flags got cout=%b ovf=%b exp 0 1", cout0, ovf0); end
        release_out();
        xact(8'h80, 8'h01, 1'b1, lat);
        n_vec++; if (out0 !== EXP_OVF_NEG) begin n_err++; $display("FAIL ovf_neg_out got %h exp %h", out0, EXP_OVF_NEG); end
        n_vec++; if (cout0 !== 1'b1 || ovf0 !== 1'b1) begin n_err++; $display("FAIL ovf_neg_flags got cout=%b ovf=%b exp 1 1", cout0, ovf0); end
        release_out();
    endtask

    task automatic test_subtract;
        int lat;
        xact(8'h10, 8'h20, 1'b1, lat);
        n_vec++; if (out0 !== 8'hF0) begin n_err++; $display("FAIL sub_borrow_out got %h exp f0", out0); end
        n_vec++; if (cout0 !== 1'b0 || ovf0 !== 1'b0) begin n_err++; $display("FAIL sub_borrow_flags got cout=%b ovf=%b exp 0 0", cout0, ovf0); end
        release_out();
        xact(8'h20, 8'h10, 1'b1, lat);
        n_vec++; if (out0 !== 8'h10) begin n_err++; $display("FAIL sub_out got %h exp 10", out0); end
        n_vec++; if (cout0 !== 1'b1 || ovf0 !== 1'b0) begin n_err++; $display("FAIL sub_flags got cout=%b ovf=%b exp 1 0", cout0, ovf0); end
        release_out();
    endtask

    task automatic test_keys;
        int lat;
        xact(8'h00, 8'h00, 1'b0, lat);
        n_vec++; if (out2 !== 8'h18) begin n_err++; $display("FAIL keys_out got %h exp 18", out2); end
        n_vec++; if (cout2 !== 1'b1 || ovf2 !== 1'b0) begin n_err++; $display("FAIL keys_flags got cout=%b ovf=%b exp 1 0", cout2, ovf2); end
        release_out();
    endtask

    task automatic test_wide;
        int lat;
        @(negedge clk);
        n_vec++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL wide_in_ready got %b exp 1", in_ready1); end
        a1 = 16'hFFFF; b1 = 16'h0001; sub1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 0;
        while (out_valid1 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++; if (lat != 4) begin n_err++; $display("FAIL wide_latency got %0d exp 4", lat); end
        n_vec++; if (out1 !== 16'h0000) begin n_err++; $display("FAIL wide_out got %h exp 0000", out1); end
        n_vec++; if (cout1 !== 1'b1 || ovf1 !== 1'b0) begin n_err++; $display("FAIL wide_flags got cout=%b ovf=%b exp 1 0", cout1, ovf1); end
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        n_vec++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL wide_release got %b exp 1", in_ready1); end
    endtask

    task automatic test_backpressure;
        int lat;
        xact(8'h10, 8'h20, 1'b1, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 8'hAA; b = 8'h55; sub = 1'b0; in_valid = (i % 2 == 0);
            n_vec++; if (out0 !== 8'hF0 || cout0 !== 1'b0 || ovf0 !== 1'b0)
                begin n_err++; $display("FAIL bp_stable cyc %0d got %h/%b/%b exp f0/0/0", i, out0, cout0, ovf0); end
            n_vec++; if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0)
                begin n_err++; $display("FAIL bp_hs cyc %0d got out_valid=%b in_ready=%b exp 1 0", i, out_valid0, in_ready0); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out();
    endtask

    task automatic test_back_to_back;
        int lat;
        xact(8'h20, 8'h10, 1'b1, lat);
        n_vec++; if (lat != 11) begin n_err++; $display("FAIL b2b_latency got %0d exp 11", lat); end
        n_vec++; if (out0 !== 8'h10 || cout0 !== 1'b1) begin n_err++; $display("FAIL b2b_result got %h/%b exp 10/1", out0, cout0); end
        release_out();
    endtask

    task automatic test_reset_mid_add;
        int lat;
        @(negedge clk);
        a = 8'h35; b = 8'h4A; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (out0 !== 8'h00) begin n_err++; $display("FAIL rst_add_out got %h exp 00", out0); end
        n_vec++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin n_err++; $display("FAIL rst_add_hs got out_valid=%b in_ready=%b exp 0 1", out_valid0, in_ready0); end
        n_vec++; if (cout0 !== 1'b0 || ovf0 !== 1'b0) begin n_err++; $display("FAIL rst_add_flags got cout=%b ovf=%b exp 0 0", cout0, ovf0); end
        @(negedge clk);
        rst = 1'b0;
        xact(8'h35, 8'h4A, 1'b0, lat);
        n_vec++; if (lat != 11 || out0 !== 8'h7F) begin n_err++; $display("FAIL rst_fresh got lat=%0d out=%h exp 11 7f", lat, out0); end
        release_out();
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_subtract();
        test_keys();
        test_wide();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_add();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule
